// File: rtl/gate_stim_checker.sv
// Stimulus sequencer and checker for a 2-input combinational gate.
// Sweeps {x,y} through 00..11, samples z after a settle time, reports results.
module gate_stim_checker #(
  parameter logic [3:0] EXP_TT        = 4'b1000,
  parameter int         SETTLE_CYCLES = 2,
  parameter int         NUM_PASSES    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       x,
  output logic       y,
  input  logic       z,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] PASS_LAST   = 4'(NUM_PASSES - 1);

  state_t     state;
  logic [1:0] idx;
  logic [3:0] pass_cnt;
  logic [3:0] settle_cnt;
  logic [2:0] wrk_cnt;
  logic [3:0] wrk_fail;

  logic       mism;
  logic       last;
  logic [1:0] idx_nxt;
  logic [2:0] cnt_nxt;
  logic [3:0] fail_nxt;

  always_comb begin
    mism     = (z != EXP_TT[idx]);
    last     = (idx == 2'd3) && (pass_cnt == PASS_LAST);
    idx_nxt  = idx + 2'd1;
    cnt_nxt  = wrk_cnt;
    fail_nxt = wrk_fail;
    if (mism) begin
      fail_nxt = wrk_fail | (4'b0001 << idx);
      if (wrk_cnt != 3'd7) cnt_nxt = wrk_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      pass_cnt   <= '0;
      settle_cnt <= '0;
      wrk_cnt    <= '0;
      wrk_fail   <= '0;
      x          <= 1'b0;
      y          <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_vec   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          x    <= 1'b0;
          y    <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            idx        <= '0;
            pass_cnt   <= '0;
            settle_cnt <= '0;
            wrk_cnt    <= '0;
            wrk_fail   <= '0;
            busy       <= 1'b1;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          settle_cnt <= settle_cnt + 4'd1;
          if (settle_cnt == SETTLE_LAST) state <= SAMPLE;
        end
        SAMPLE: begin
          wrk_cnt  <= cnt_nxt;
          wrk_fail <= fail_nxt;
          if (last) begin
            // results become visible together with the done pulse
            busy      <= 1'b0;
            done      <= 1'b1;
            x         <= 1'b0;
            y         <= 1'b0;
            err_count <= cnt_nxt;
            fail_vec  <= fail_nxt;
            pass      <= (cnt_nxt == 3'd0);
            state     <= DONE;
          end else begin
            idx        <= idx_nxt;
            settle_cnt <= '0;
            x          <= idx_nxt[1];
            y          <= idx_nxt[0];
            if (idx == 2'd3) pass_cnt <= pass_cnt + 4'd1;
            state <= SETTLE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_stim_checker.sv
// Randomized self-checking bench for gate_stim_checker.
// Two instances: default parameters and NUM_PASSES=3 / SETTLE_CYCLES=1.
module tb_gate_stim_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start1, start2, sel;
  logic [3:0] tt;
  logic       x1, y1, z1, busy1, done1, pass1;
  logic [2:0] err1;
  logic [3:0] fail1;
  logic       x2, y2, z2, busy2, done2, pass2;
  logic [2:0] err2;
  logic [3:0] fail2;

  assign z1 = tt[{x1, y1}];
  assign z2 = tt[{x2, y2}];

  gate_stim_checker dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .x(x1), .y(y1), .z(z1),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_vec(fail1)
  );

  gate_stim_checker #(
    .EXP_TT(4'b1000), .SETTLE_CYCLES(1), .NUM_PASSES(3)
  ) dut2 (
    .clk(clk), .rst(rst), .start(start2),
    .x(x2), .y(y2), .z(z2),
    .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .fail_vec(fail2)
  );

  logic       ox, oy, obusy, odone, opass;
  logic [2:0] oerr;
  logic [3:0] ofail;
  assign ox    = sel ? x2 : x1;
  assign oy    = sel ? y2 : y1;
  assign obusy = sel ? busy2 : busy1;
  assign odone = sel ? done2 : done1;
  assign opass = sel ? pass2 : pass1;
  assign oerr  = sel ? err2 : err1;
  assign ofail = sel ? fail2 : fail1;

  int n_chk = 0;
  int n_fail = 0;

  int         o_lat, o_xyerr, o_busy, o_done;
  bit         o_chg;
  logic       o_pass;
  logic [2:0] o_err;
  logic [3:0] o_fail;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // expected results from the truth-table rules
  function automatic void model(input logic [3:0] g, input int np,
                                output logic [2:0] cnt,
                                output logic [3:0] f);
    logic [3:0] e = 4'b1000;
    int raw = 0;
    f = '0;
    for (int p = 0; p < np; p++)
      for (int i = 0; i < 4; i++)
        if (g[i] !== e[i]) begin
          raw++;
          f[i] = 1'b1;
        end
    cnt = (raw > 7) ? 3'd7 : 3'(raw);
  endfunction

  // drive one run and record observations
  task automatic run(input bit which, input int s, input int np,
                     input bit spam);
    int total = 4 * np * (s + 1);
    logic pp;
    logic [2:0] pe;
    logic [3:0] pf;
    sel = which;
    #0;
    pp = opass; pe = oerr; pf = ofail;
    o_lat = -1; o_xyerr = 0; o_busy = 0; o_done = 0; o_chg = 0;
    o_pass = 1'bx; o_err = 'x; o_fail = 'x;
    if (which) start2 = 1'b1; else start1 = 1'b1;
    tick;
    for (int c = 1; c <= total + 5; c++) begin
      if (odone) begin
        o_done++;
        if (o_lat < 0) o_lat = c;
        o_pass = opass; o_err = oerr; o_fail = ofail;
        if (ox || oy || obusy) o_xyerr++;
      end else if (o_done == 0 && {opass, oerr, ofail} !== {pp, pe, pf})
        o_chg = 1;
      if (obusy) o_busy++;
      if (c <= total) begin
        int comb = ((c - 1) / (s + 1)) % 4;
        if (!obusy || {ox, oy} !== 2'(comb)) o_xyerr++;
      end
      if (!spam || o_done > 0) begin
        start1 = 1'b0;
        start2 = 1'b0;
      end
      tick;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start1 = 1'b1; start2 = 1'b1; tt = 4'b1000; sel = 0;
    tick; tick;
    n_chk++;
    if ({x1, y1, busy1, done1, pass1, err1, fail1} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_dut1 got %b want 0",
               {x1, y1, busy1, done1, pass1, err1, fail1});
    end
    n_chk++;
    if ({x2, y2, busy2, done2, pass2, err2, fail2} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_dut2 got %b want 0",
               {x2, y2, busy2, done2, pass2, err2, fail2});
    end
    start1 = 1'b0; start2 = 1'b0;
    rst = 1'b0;
    tick; tick;
    n_chk++;
    if (busy1 !== 1'b0 || busy2 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_start_ignored busy %b%b want 00", busy1, busy2);
    end
  endtask

  task automatic test_gate_sweep(input string nm, input bit which,
                                 input logic [3:0] g, input bit spam);
    int s  = which ? 1 : 2;
    int np = which ? 3 : 1;
    int total = 4 * np * (s + 1);
    logic [2:0] ec;
    logic [3:0] ef;
    tt = g;
    model(g, np, ec, ef);
    run(which, s, np, spam);
    n_chk++;
    if (o_lat !== total + 1 || o_done !== 1) begin
      n_fail++;
      $display("FAIL %s done_timing lat %0d cnt %0d want lat %0d cnt 1",
               nm, o_lat, o_done, total + 1);
    end
    n_chk++;
    if (o_busy !== total || o_xyerr !== 0) begin
      n_fail++;
      $display("FAIL %s sweep busy %0d xyerr %0d want busy %0d xyerr 0",
               nm, o_busy, o_xyerr, total);
    end
    n_chk++;
    if ({o_pass, o_err, o_fail} !== {(ec == 3'd0), ec, ef}) begin
      n_fail++;
      $display("FAIL %s result pass %b err %0d fail %b want %b %0d %b",
               nm, o_pass, o_err, o_fail, (ec == 3'd0), ec, ef);
    end
    n_chk++;
    if (o_chg || {opass, oerr, ofail} !== {o_pass, o_err, o_fail}) begin
      n_fail++;
      $display("FAIL %s result_hold chg %0d now %b%0d%b", nm, o_chg,
               opass, oerr, ofail);
    end
  endtask

  task automatic test_mid_reset;
    int dn = 0;
    test_gate_sweep("pre_nand", 0, 4'b0111, 0);
    tt = 4'b0000;
    sel = 0;
    start1 = 1'b1;
    tick;
    start1 = 1'b0;
    for (int c = 1; c < 5; c++) tick;
    n_chk++;
    if (busy1 !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_busy5 got %b want 1", busy1);
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_chk++;
    if ({x1, y1, busy1, done1, pass1, err1, fail1} !== 11'd0) begin
      n_fail++;
      $display("FAIL midrst_outputs got %b want 0",
               {x1, y1, busy1, done1, pass1, err1, fail1});
    end
    for (int c = 0; c < 20; c++) begin
      if (done1 || busy1) dn++;
      tick;
    end
    n_chk++;
    if (dn !== 0) begin
      n_fail++;
      $display("FAIL midrst_no_done active cycles %0d want 0", dn);
    end
    test_gate_sweep("post_rst_and", 0, 4'b1000, 0);
  endtask

  task automatic test_back_to_back;
    int lat = -1;
    bit seen = 0;
    tt = 4'b0000;
    sel = 0;
    start1 = 1'b1;
    tick;
    start1 = 1'b0;
    for (int c = 1; c <= 30 && !seen; c++) begin
      if (done1) seen = 1;
      else tick;
    end
    n_chk++;
    if (!seen || err1 !== 3'd1 || fail1 !== 4'b1000) begin
      n_fail++;
      $display("FAIL b2b_first seen %0d err %0d fail %b want 1 1 1000",
               seen, err1, fail1);
    end
    start1 = 1'b1;
    tt = 4'b1000;
    tick;
    n_chk++;
    if (busy1 !== 1'b0 || done1 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle busy %b done %b want 0 0", busy1, done1);
    end
    tick;
    start1 = 1'b0;
    n_chk++;
    if (busy1 !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_restart busy %b want 1", busy1);
    end
    for (int c = 1; c <= 30 && lat < 0; c++) begin
      tick;
      if (done1) lat = c + 1;
    end
    n_chk++;
    if (lat !== 13 || pass1 !== 1'b1 || err1 !== 3'd0 || fail1 !== 4'd0) begin
      n_fail++;
      $display("FAIL b2b_second lat %0d pass %b err %0d fail %b want 13 1 0 0",
               lat, pass1, err1, fail1);
    end
  endtask

  initial begin
    rst = 1'b1; start1 = 1'b0; start2 = 1'b0; sel = 1'b0; tt = 4'b1000;
    test_reset;
    test_gate_sweep("and", 0, 4'b1000, 0);
    test_gate_sweep("tie0", 0, 4'b0000, 0);
    test_gate_sweep("nand", 0, 4'b0111, 0);
    test_gate_sweep("tie1_multi", 1, 4'b1111, 0);
    test_gate_sweep("and_multi", 1, 4'b1000, 0);
    test_gate_sweep("spam_nand", 0, 4'b0111, 1);
    test_gate_sweep("spam_multi", 1, 4'b0110, 1);
    for (int i = 0; i < 6; i++)
      test_gate_sweep("rand", 0, 4'($urandom_range(0, 15)), 0);
    for (int i = 0; i < 3; i++)
      test_gate_sweep("rand_multi", 1, 4'($urandom_range(0, 15)), 0);
    test_mid_reset;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
